fir_16_tap: RTL and testbench
=============================

FIR_16_TAP -- requirements
Module: fir_16_tap

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 run  input  1  start request; sampled on a rising clk edge while idle.
REQ-006 busy  output  1  high while a request is accepted or in progress.
REQ-007 sample_in  input  16  new sample, signed two's complement.
REQ-008 coeff0..coeff15  input  16 each  tap coefficients, unsigned Q0.16 (0x10000 = 1.0); coeff0 applies to the newest sample.
REQ-009 filter_data  output  16  filtered result, signed two's complement, registered.

Function
REQ-010 The delay line SHALL be 16 signed 16-bit entries, tap[0]..tap[15], where tap[0] is the newest sample.
REQ-011 The block SHALL use three states: IDLE, MAC and DONE.
REQ-012 In IDLE, when run=1 at edge E0, the block SHALL:
- shift the delay line (tap[i] <= tap[i-1], tap[0] <= sample_in);
- clear the accumulator;
- set the tap index to 0;
- enter MAC.
REQ-013 In MAC, at each edge E1..E16 the block SHALL:
- add tap[idx] * coeff[idx] to the accumulator (signed 16 x unsigned 16, sign-correct product);
- increment idx;
- leave MAC for DONE at E16, after idx 15 is accumulated.
REQ-014 The accumulator SHALL be signed and at least 37 bits wide, so that no internal overflow is possible.
REQ-015 In DONE, at edge E17 the block SHALL load filter_data with the accumulator arithmetically shifted right 16 (floor), saturated to [-32768, 32767], and return to IDLE.
REQ-016 busy SHALL equal (state != IDLE) OR run, combinationally, so that busy is already high in the same cycle run is first presented.
REQ-017 busy SHALL fall after E17; filter_data is valid from that cycle on, for a total latency of 17 cycles from the accepting edge.
REQ-018 filter_data SHALL hold its value between operations and change only at DONE or on reset.
REQ-019 The block SHALL ignore run while in MAC or DONE: no restart and no extra shift.
REQ-020 If run is held high continuously, a new operation SHALL start on the first IDLE edge after DONE.
REQ-021 Coefficients SHALL be read live during MAC; the user holds them stable, and a coefficient changed mid-operation takes effect for taps not yet accumulated.
REQ-022 Each accepted run SHALL consume exactly one sample; there is no other way to advance the delay line.

Reset
REQ-023 On rst=1 the block SHALL immediately, regardless of clk:
- set state to IDLE and the index to 0;
- clear the accumulator and all 16 delay-line entries;
- set filter_data to 0x0000;
- drive busy to the value of run only.
REQ-024 A reset during MAC or DONE SHALL abort the operation without updating filter_data, beyond clearing it to 0.
REQ-025 Operation SHALL resume on the first clk edge after rst deasserts.

Verification
REQ-026 Passthrough (coeff0=0xFFFF, others 0):
- sample 1000 -> filter_data = 999 (0x03E7);
- sample -1000 -> filter_data = -1000 (0xFC18).
REQ-027 Moving average (all coeffs 0x1000), 16 runs of sample 256 from reset -> outputs 16, 32, ..., 256; the 17th run with sample 0 -> 240.
REQ-028 Delay window (coeff2..coeff5=0x4000, others 0), impulse 400 then zeros -> outputs 0, 0, 100, 100, 100, 100, 0.
REQ-029 Saturation (all coeffs 0xFFFF):
- 16 runs of 32767 -> filter_data = 32767 (0x7FFF);
- then 16 runs of -32768 -> 0x8000.
REQ-030 Handshake and reset:
- run pulsed one cycle -> busy high that same cycle, stays high through 17 edges, and filter_data updates as busy falls;
- run re-pulsed mid-MAC -> ignored, with a single shift only;
- rst asserted at MAC idx 8 -> busy=0, filter_data=0, delay line zero, so a following passthrough run of 5 -> 4.

Source files
------------

// File: rtl/fir_16_tap.sv
// 16-tap FIR filter: one sample consumed per run request, taps accumulated
// sequentially over 16 cycles, result rounded toward -inf and saturated.
module fir_16_tap (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        busy,
    input  logic [15:0] sample_in,
    input  logic [15:0] coeff0,
    input  logic [15:0] coeff1,
    input  logic [15:0] coeff2,
    input  logic [15:0] coeff3,
    input  logic [15:0] coeff4,
    input  logic [15:0] coeff5,
    input  logic [15:0] coeff6,
    input  logic [15:0] coeff7,
    input  logic [15:0] coeff8,
    input  logic [15:0] coeff9,
    input  logic [15:0] coeff10,
    input  logic [15:0] coeff11,
    input  logic [15:0] coeff12,
    input  logic [15:0] coeff13,
    input  logic [15:0] coeff14,
    input  logic [15:0] coeff15,
    output logic [15:0] filter_data
);
    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic signed [15:0] r_tap [16];
    logic signed [39:0] r_acc;
    logic [3:0]         r_idx;
    logic [15:0]        w_coeff [16];
    logic signed [32:0] w_prod;
    logic signed [39:0] w_shift;
    logic [15:0]        w_sat;

    assign w_coeff[0]  = coeff0;
    assign w_coeff[1]  = coeff1;
    assign w_coeff[2]  = coeff2;
    assign w_coeff[3]  = coeff3;
    assign w_coeff[4]  = coeff4;
    assign w_coeff[5]  = coeff5;
    assign w_coeff[6]  = coeff6;
    assign w_coeff[7]  = coeff7;
    assign w_coeff[8]  = coeff8;
    assign w_coeff[9]  = coeff9;
    assign w_coeff[10] = coeff10;
    assign w_coeff[11] = coeff11;
    assign w_coeff[12] = coeff12;
    assign w_coeff[13] = coeff13;
    assign w_coeff[14] = coeff14;
    assign w_coeff[15] = coeff15;

    // Coefficient is zero-extended so the signed multiply treats it as unsigned Q0.16.
    assign w_prod  = r_tap[r_idx] * $signed({1'b0, w_coeff[r_idx]});
    assign w_shift = r_acc >>> 16;

    always_comb begin
        if (w_shift > 40'sd32767)
            w_sat = 16'h7FFF;
        else if (w_shift < -40'sd32768)
            w_sat = 16'h8000;
        else
            w_sat = w_shift[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (run) w_next = S_MAC;
            S_MAC:   if (r_idx == 4'd15) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE) || run;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_tap[i] <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            filter_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (run) begin
                    for (int i = 15; i > 0; i--) r_tap[i] <= r_tap[i-1];
                    r_tap[0] <= sample_in;
                    r_acc    <= '0;
                    r_idx    <= '0;
                end
                S_MAC: begin
                    r_acc <= r_acc + $signed({{7{w_prod[32]}}, w_prod});
                    r_idx <= r_idx + 4'd1;
                end
                S_DONE:  filter_data <= w_sat;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_16_tap.sv
// Bench for fir_16_tap: table of spec vectors through a scoreboard queue,
// plus hand sequences for mid-MAC rerun and mid-MAC reset.
module tb_fir_16_tap;
    logic        clk = 0;
    logic        rst = 0;
    logic        run = 0;
    logic        busy;
    logic [15:0] sample_in = '0;
    logic [15:0] co [16];
    logic [15:0] filter_data;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] last_out = '0;
    logic [15:0] exp_q [$];

    typedef struct {
        int          cfg;
        bit          rst_b;
        logic [15:0] s;
        logic [15:0] e;
    } vec_t;
    vec_t vt [64];
    int   nv = 0;

    always #5 clk = ~clk;

    fir_16_tap dut (
        .clk(clk), .rst(rst), .run(run), .busy(busy), .sample_in(sample_in),
        .coeff0(co[0]),   .coeff1(co[1]),   .coeff2(co[2]),   .coeff3(co[3]),
        .coeff4(co[4]),   .coeff5(co[5]),   .coeff6(co[6]),   .coeff7(co[7]),
        .coeff8(co[8]),   .coeff9(co[9]),   .coeff10(co[10]), .coeff11(co[11]),
        .coeff12(co[12]), .coeff13(co[13]), .coeff14(co[14]), .coeff15(co[15]),
        .filter_data(filter_data)
    );

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void set_cfg(input int c);
        for (int i = 0; i < 16; i++) co[i] = 16'h0000;
        case (c)
            0: co[0] = 16'hFFFF;
            1: for (int i = 0; i < 16; i++) co[i] = 16'h1000;
            2: for (int i = 2; i < 6; i++) co[i] = 16'h4000;
            3: for (int i = 0; i < 16; i++) co[i] = 16'hFFFF;
            4: co[1] = 16'hFFFF;
            default: ;
        endcase
    endfunction

    function automatic void add(input int c, input bit r, input logic [15:0] s, input logic [15:0] e);
        vt[nv] = '{cfg: c, rst_b: r, s: s, e: e};
        nv++;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        #1;
        chk("rst_busy", {15'b0, busy}, {15'b0, run});
        chk("rst_filter", filter_data, 16'h0000);
        @(negedge clk);
        rst = 0;
        last_out = '0;
    endtask

    // One accepted run; optionally re-pulses run after edge `repulse` of the MAC.
    task automatic run_op(input logic [15:0] s, input logic [15:0] e, input int repulse, input string name);
        int n;
        logic [15:0] ex;
        @(negedge clk);
        run = 1;
        sample_in = s;
        #1;
        chk("busy_same_cycle", {15'b0, busy}, 16'd1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        run = 0;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 16) chk("hold_before_done", filter_data, last_out);
            if (n == repulse) begin
                run = 1;
                sample_in = 16'h0309;
            end else if (n == repulse + 1) begin
                run = 0;
            end
        end
        chk("latency", n[15:0], 16'd17);
        ex = exp_q.pop_front();
        chk(name, filter_data, ex);
        last_out = ex;
    endtask

    initial begin
        set_cfg(0);
        // passthrough
        add(0, 1, 16'd1000, 16'h03E7);
        add(0, 0, 16'hFC18, 16'hFC18);
        // moving average
        for (int k = 1; k <= 16; k++) add(1, k == 1, 16'd256, 16'(k * 16));
        add(1, 0, 16'd0, 16'd240);
        // delay window
        add(2, 1, 16'd400, 16'd0);
        add(2, 0, 16'd0, 16'd0);
        for (int k = 0; k < 4; k++) add(2, 0, 16'd0, 16'd100);
        add(2, 0, 16'd0, 16'd0);
        // saturation, including the near-zero crossing at 8 negative samples
        add(3, 1, 16'h7FFF, 16'd32766);
        for (int k = 2; k <= 16; k++) add(3, 0, 16'h7FFF, 16'h7FFF);
        for (int j = 1; j <= 16; j++)
            add(3, 0, 16'h8000, (j < 8) ? 16'h7FFF : (j == 8) ? 16'hFFF8 : 16'h8000);

        rst = 1;
        #12;
        chk("por_filter", filter_data, 16'h0000);
        chk("por_busy", {15'b0, busy}, 16'd0);
        rst = 0;

        for (int i = 0; i < nv; i++) begin
            set_cfg(vt[i].cfg);
            if (vt[i].rst_b) do_reset();
            run_op(vt[i].s, vt[i].e, -1, $sformatf("vec%0d", i));
        end

        // rerun during MAC must not shift again: tap1 must still be 1000
        do_reset();
        set_cfg(0);
        run_op(16'd1000, 16'd999, 5, "repulse_op");
        set_cfg(4);
        run_op(16'd0, 16'd999, -1, "repulse_single_shift");

        // reset at MAC idx 8 aborts the run and clears the delay line
        set_cfg(0);
        run_op(16'd1000, 16'd999, -1, "pre_abort");
        @(negedge clk);
        run = 1;
        sample_in = 16'd1234;
        @(posedge clk);
        #1;
        run = 0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("abort_busy", {15'b0, busy}, 16'd0);
        chk("abort_filter", filter_data, 16'h0000);
        @(negedge clk);
        rst = 0;
        last_out = '0;
        run_op(16'd5, 16'd4, -1, "post_abort_pass");
        set_cfg(3);
        run_op(16'd0, 16'd4, -1, "post_abort_taps_clear");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
